// File: rtl/addsub_hex_scan.sv
// addsub_hex_scan: registered WIDTH-bit add/subtract with carry/borrow flag and
// a time-multiplexed hex 7-segment scan of the result (NDIG = WIDTH/4 digits).
// Optional feature: define ADDSUB_LZ_BLANK_EN for leading-zero blanking.
module addsub_hex_scan #(
  parameter int WIDTH    = 8,
  parameter int SCAN_DIV = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               op_sub,
  output logic               res_valid,
  output logic [WIDTH-1:0]   result,
  output logic               ovf,
  output logic [6:0]         seg,
  output logic [WIDTH/4-1:0] an
);

  localparam int NDIG = WIDTH / 4;
  localparam int CW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NDIG - 1);
  localparam logic [6:0]    SEG_OVF   = 7'b0011101;

  typedef enum logic [1:0] {IDLE, CALC, SHOW} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              sub_q;
  logic [WIDTH-1:0]  result_q;
  logic              ovf_q;
  logic [CW-1:0]     scan_cnt_q;
  logic [DW-1:0]     d_q;
  logic              load, commit;
  logic [WIDTH:0]    sum_w;
  logic [3:0]        nib;
  logic              blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1111110;  4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;  4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;  4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;  4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;  4'h9: hex7 = 7'b1111011;
      4'hA: hex7 = 7'b1110111;  4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110;  4'hD: hex7 = 7'b0111101;
      4'hE: hex7 = 7'b1001111;  default: hex7 = 7'b1000111;
    endcase
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state, handshake and strobes; reset forces in_ready low
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    load      = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        commit  = 1'b1;
        state_d = SHOW;
      end
      SHOW: begin
        in_ready  = 1'b1;
        res_valid = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

  // WIDTH+1-bit sum/difference; the top bit is carry for add, borrow for sub
  always_comb begin
    if (sub_q) sum_w = {1'b0, a_q} - {1'b0, b_q};
    else       sum_w = {1'b0, a_q} + {1'b0, b_q};
  end

  // Operand capture on handshake, result registration in CALC
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (load) begin
        a_q   <= a;
        b_q   <= b;
        sub_q <= op_sub;
      end
      if (commit) begin
        result_q <= sum_w[WIDTH-1:0];
        ovf_q    <= sum_w[WIDTH];
      end
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;

  // Free-running scan divider and digit index, independent of the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      d_q        <= '0;
    end else if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_q <= '0;
      d_q        <= (d_q == DIG_LAST) ? '0 : d_q + 1'b1;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

`ifdef ADDSUB_LZ_BLANK_EN
  // Blank the current digit when it and every nibble above it are zero
  always_comb begin
    blank = 1'b0;
    for (int unsigned i = 1; i < NDIG; i++) begin
      if (d_q == DW'(i) && ((result_q >> (4 * i)) == '0)) blank = 1'b1;
    end
    if (ovf_q) blank = 1'b0;
  end
`else
  assign blank = 1'b0;
`endif

  // Digit select and segment decode for the current scan slot
  always_comb begin
    nib = 4'h0;
    an  = '0;
    seg = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (d_q == DW'(i)) nib = result_q[4*i +: 4];
    end
    if (state_q == SHOW && !blank) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        an[i] = (d_q == DW'(i));
      end
      seg = ovf_q ? SEG_OVF : hex7(nib);
    end
  end

endmodule

// File: tb/tb_addsub_hex_scan.sv
// Bench for addsub_hex_scan at WIDTH=8, SCAN_DIV=4. Expected results are pushed
// to a queue when operands are handed over and popped when res_valid rises.
module tb_addsub_hex_scan;
  localparam int W  = 8;
  localparam int SD = 4;
  localparam int ND = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         op_sub = 1'b0;
  logic         res_valid;
  logic [W-1:0] result;
  logic         ovf;
  logic [6:0]   seg;
  logic [ND-1:0] an;

  int checks   = 0;
  int failures = 0;
  logic [W:0] exp_q[$];
  int m_cnt = 0;
  int m_d   = 0;
  logic rv_prev = 1'b0;

  addsub_hex_scan #(.WIDTH(W), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub), .res_valid(res_valid),
    .result(result), .ovf(ovf), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  // Reference scan position
  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0;
      m_d   <= 0;
    end else if (m_cnt == SD - 1) begin
      m_cnt <= 0;
      m_d   <= (m_d + 1) % ND;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
          7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    return t[n];
  endfunction

  // Scoreboard: each rising res_valid consumes one expected {ovf,result}
  always @(negedge clk) begin
    logic [W:0] e;
    if (res_valid === 1'b1 && rv_prev !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got=%h required=none", {ovf, result});
      end else begin
        e = exp_q.pop_front();
        if ({ovf, result} !== e) begin
          failures++;
          $display("FAIL sb_result got=%h required=%h", {ovf, result}, e);
        end
      end
    end
    rv_prev = res_valid;
  end

  // Drive one operand pair with in_valid high (caller is at a negedge)
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic sub, input bit expect_result);
    a = ta; b = tb; op_sub = sub; in_valid = 1'b1;
    if (expect_result)
      exp_q.push_back(sub ? ({1'b0, ta} - {1'b0, tb}) : ({1'b0, ta} + {1'b0, tb}));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a = 8'h12; b = 8'h34; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || res_valid !== 1'b0 || an !== '0 || seg !== '0) begin
        failures++;
        $display("FAIL reset_hold rdy=%b rv=%b an=%b seg=%b required 0,0,00,0000000",
                 in_ready, res_valid, an, seg);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || res_valid !== 1'b0 || an !== '0 || seg !== '0 || result !== '0) begin
        failures++;
        $display("FAIL reset_idle rdy=%b rv=%b an=%b seg=%b res=%h required 1,0,00,0,00",
                 in_ready, res_valid, an, seg, result);
      end
    end
  endtask

  task automatic test_add();
    send(8'h3C, 8'h05, 1'b0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_calc rdy=%b rv=%b required 0,0", in_ready, res_valid);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || result !== 8'h41 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL add_result rv=%b res=%h ovf=%b required 1,41,0", res_valid, result, ovf);
    end
    // Operand changes without a handshake must not disturb the held result
    a = 8'hAA; b = 8'h55; op_sub = 1'b1;
    for (int i = 0; i < 3 * SD * ND; i++) begin
      logic [W-1:0] r;
      logic [ND-1:0] ea;
      logic [6:0] es;
      r  = 8'h41;
      ea = ND'(1 << m_d);
      es = ref_seg(r[4*m_d +: 4]);
      checks++;
      if (an !== ea || seg !== es || result !== 8'h41 || res_valid !== 1'b1) begin
        failures++;
        $display("FAIL add_scan an=%b seg=%b res=%h required an=%b seg=%b res=41",
                 an, seg, result, ea, es);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sub_ovf();
    send(8'h05, 8'h3C, 1'b1, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (result !== 8'hC9 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL sub_result res=%h ovf=%b required c9,1", result, ovf);
    end
    for (int i = 0; i < SD * ND; i++) begin
      checks++;
      if (an !== ND'(1 << m_d) || seg !== 7'b0011101) begin
        failures++;
        $display("FAIL sub_scan an=%b seg=%b required an=%b seg=0011101",
                 an, seg, ND'(1 << m_d));
      end
      @(negedge clk);
    end
    send(8'hFF, 8'h01, 1'b0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (result !== 8'h00 || ovf !== 1'b1 || seg !== 7'b0011101) begin
      failures++;
      $display("FAIL add_wrap res=%h ovf=%b seg=%b required 00,1,0011101", result, ovf, seg);
    end
    send(8'h00, 8'h01, 1'b1, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (result !== 8'hFF || ovf !== 1'b1) begin
      failures++;
      $display("FAIL sub_wrap res=%h ovf=%b required ff,1", result, ovf);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] rv_pat;
    logic [2:0] rdy_pat;
    send(8'h10, 8'h01, 1'b0, 1);
    @(negedge clk);
    rv_pat[2] = res_valid; rdy_pat[2] = in_ready;
    in_valid = 1'b0;
    @(negedge clk);
    rv_pat[1] = res_valid; rdy_pat[1] = in_ready;
    checks++;
    if (result !== 8'h11 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first res=%h ovf=%b required 11,0", result, ovf);
    end
    send(8'h20, 8'h01, 1'b1, 1);
    @(negedge clk);
    in_valid = 1'b0;
    rv_pat[0] = res_valid; rdy_pat[0] = in_ready;
    checks++;
    if (rv_pat !== 3'b010 || rdy_pat !== 3'b010) begin
      failures++;
      $display("FAIL b2b_pattern rv=%b rdy=%b required 010,010", rv_pat, rdy_pat);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || result !== 8'h1F || ovf !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second rv=%b res=%h ovf=%b rdy=%b required 1,1f,0,1",
               res_valid, result, ovf, in_ready);
    end
  endtask

  task automatic test_reset_in_calc();
    send(8'h33, 8'h44, 1'b0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_calc_ready rdy=%b required 0", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || result !== 8'h00 || ovf !== 1'b0 || in_ready !== 1'b1 || an !== '0) begin
        failures++;
        $display("FAIL rst_calc rv=%b res=%h ovf=%b rdy=%b an=%b required 0,00,0,1,00",
                 res_valid, result, ovf, in_ready, an);
      end
    end
  endtask

  task automatic test_lz();
    send(8'h00, 8'h07, 1'b0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2 * SD * ND; i++) begin
      logic [ND-1:0] ea;
      logic [6:0] es;
      if (m_d == 0) begin
        ea = 2'b01; es = 7'b1110000;
      end else begin
`ifdef ADDSUB_LZ_BLANK_EN
        ea = 2'b00; es = 7'b0000000;
`else
        ea = 2'b10; es = 7'b1111110;
`endif
      end
      checks++;
      if (an !== ea || seg !== es) begin
        failures++;
        $display("FAIL lz_scan d=%0d an=%b seg=%b required an=%b seg=%b", m_d, an, seg, ea, es);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_ovf();
    test_back_to_back();
    test_reset_in_calc();
    test_lz();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_hex_scan.md
# addsub_hex_scan

Registered, parametrised add/subtract unit with a time-multiplexed hexadecimal 7-segment display driver. It accepts an operand pair and an operation through a valid/ready handshake, produces a WIDTH-bit result with a carry/borrow flag, and scans the result as WIDTH/4 hex digits onto a shared segment bus. It is the clocked, multi-digit successor of the team's single-digit combinational add/sub-to-7-segment path and sits between the operand entry logic and the board display pins.

## Interface
- WIDTH, 8: operand and result width. Must be a multiple of 4, range 4..16. Derived NDIG = WIDTH/4.
- SCAN_DIV, 1024: clock cycles each digit is held during scanning. Must be >= 2.
- clk, input, 1: single clock, rising-edge.
- rst, input, 1: reset. Synchronous and active-high.
- in_valid, input, 1: operand pair presented.
- in_ready, output, 1: block accepts a new operand pair.
- a, input, WIDTH: operand A, unsigned.
- b, input, WIDTH: operand B, unsigned.
- op_sub, input, 1: operation select. 0 = A+B, 1 = A-B. Sampled with the operands.
- res_valid, output, 1: result, ovf and display are valid.
- result, output, WIDTH: low WIDTH bits of the sum or difference.
- ovf, output, 1: carry-out for add; borrow (A<B) for subtract.
- seg, output, 7: segments {a,b,c,d,e,f,g}, with a in the MSB. Active-high.
- an, output, NDIG: digit enables, one-hot, active-high. Bit i selects the nibble result[4i+3:4i].

## Operation
- FSM states are IDLE, CALC, SHOW. Reset enters IDLE.
- IDLE:
  - in_ready=1, res_valid=0.
  - Handshake (in_valid & in_ready) captures a, b, op_sub and moves to CALC.
- CALC (exactly 1 cycle):
  - in_ready=0.
  - Computes {ovf,result} = a+b or a-b in WIDTH+1 bits, registers it, and moves to SHOW.
- SHOW:
  - res_valid=1, in_ready=1. result and ovf are held.
  - A handshake captures the new operands, drops res_valid on the next cycle, and moves to CALC.
  - in_valid low keeps the FSM in SHOW indefinitely.
- Wrap-around:
  - Add 0xFF+0x01 at WIDTH=8 gives result 0x00, ovf=1.
  - Subtract 0x00-0x01 gives result 0xFF, ovf=1.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1 continuously in all states.
  - At the terminal count, digit index d advances 0,1,..,NDIG-1 and wraps to 0.
  - Reset clears both scan_cnt and d to 0.
- Display output:
  - In IDLE or CALC: an=0, seg=0.
  - In SHOW: an = one-hot(d).
  - In SHOW with ovf=0: seg = hex(result nibble d).
  - In SHOW with ovf=1: every digit shows 'o' (0011101).
- Hex decode:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111

## Timing
- Reset values: res_valid=0, result=0, ovf=0, seg=0, an=0, FSM=IDLE.
- in_ready is forced to 0 during any cycle in which rst=1.
- Latency:
  - Handshake sampled at edge N, FSM in CALC after edge N.
  - result, ovf and res_valid are updated at edge N+1.
  - an is active from edge N+1 onward.
- Throughput: one operation per 2 cycles. in_ready is low only while in CALC.
- rst has priority over a simultaneous handshake: the operands are discarded.
- Reset during CALC aborts the operation. res_valid never rises for it.
- Changing a, b or op_sub without a handshake never affects result.
- The display index d is not reset by a new operation. Scanning continues in phase.

## Configuration
- ADDSUB_LZ_BLANK_EN defined: leading-zero blanking when ovf=0.
  - A digit i > 0 is blanked if every nibble at position >= i is 0. Blanked means an=0 and seg=0 for its scan slot.
  - Digit 0 is never blanked.
  - No blanking when ovf=1.
  - Scan slot timing is unchanged.
- ADDSUB_LZ_BLANK_EN undefined: all NDIG digits are always driven in SHOW.

## Test plan
All scenarios use WIDTH=8, SCAN_DIV=4.
- Reset held for 3 cycles, then released -> in_ready=1 during cycles with rst=0, res_valid=0, an=00, seg=0; handshake in the rst cycle ignored.
- Add 0x3C+0x05 -> res_valid at handshake+2, result=0x41, ovf=0; an=01/seg=0110000 for 4 cycles, then an=10/seg=0110011 for 4 cycles, repeating.
- Subtract 0x05-0x3C -> result=0xC9, ovf=1, both digits show 0011101. Add 0xFF+0x01 -> result=0x00, ovf=1.
- Back-to-back handshakes in SHOW (0x10+0x01, then 0x20-0x01) -> res_valid pattern 1,0,1, result 0x11 then 0x1F, in_ready low only during CALC.
- rst pulsed in the CALC cycle -> FSM in IDLE, res_valid stays 0, result=0.
- Add 0x00+0x07:
  - With ADDSUB_LZ_BLANK_EN: digit-1 slot has an=00, seg=0; digit-0 slot shows 1110000.
  - Without the macro: digit 1 shows 1111110.
